// File: rtl/ysyx_22051013_ifetch_router_pkg.sv
// Shared definitions for the instruction-fetch router: FSM encoding, AXI beat
// size codes and the default cached/uncached address windows.
package ysyx_22051013_ifetch_router_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CACHED   = 3'd1,
    S_UNC_BUSY = 3'd2,
    S_HOLD     = 3'd3,
    S_FAULT    = 3'd4,
    S_DRAIN    = 3'd5
  } state_e;

  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [2:0] AXI_SIZE_8B = 3'b011;

  localparam logic [63:0] DEF_MEM_START = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DEF_MEM_END   = 64'h0000_0000_87FF_FFFF;

  // Window 0 (low slice) is the UART/CLINT-style peripheral page, window 1 the MMIO block.
  localparam logic [127:0] DEF_UNC_START = {64'h0000_0000_A000_0000, 64'h0000_0000_1000_0000};
  localparam logic [127:0] DEF_UNC_END   = {64'h0000_0000_AFFF_FFFF, 64'h0000_0000_1000_0FFF};

endpackage

// File: rtl/ysyx_22051013_ifetch_region_dec.sv
// Combinational fetch-address classifier: cached window, any uncached window,
// or unmapped. The cached window takes priority where windows overlap.
module ysyx_22051013_ifetch_region_dec
  import ysyx_22051013_ifetch_router_pkg::*;
#(
  parameter int                        ADDR_W    = 64,
  parameter int                        N_UNC     = 2,
  parameter logic [ADDR_W-1:0]         MEM_START = DEF_MEM_START,
  parameter logic [ADDR_W-1:0]         MEM_END   = DEF_MEM_END,
  parameter logic [N_UNC*ADDR_W-1:0]   UNC_START = DEF_UNC_START,
  parameter logic [N_UNC*ADDR_W-1:0]   UNC_END   = DEF_UNC_END
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_cached,
  output logic              o_uncached,
  output logic              o_unmapped
);

  logic [N_UNC-1:0] w_unc_hit;

  for (genvar g = 0; g < N_UNC; g++) begin : g_unc
    assign w_unc_hit[g] = (i_addr >= UNC_START[g*ADDR_W +: ADDR_W]) &&
                          (i_addr <= UNC_END[g*ADDR_W +: ADDR_W]);
  end

  assign o_cached   = (i_addr >= MEM_START) && (i_addr <= MEM_END);
  assign o_uncached = ~o_cached & (|w_unc_hit);
  assign o_unmapped = ~o_cached & ~(|w_unc_hit);

endmodule

// File: rtl/ysyx_22051013_ifetch_router.sv
// Routes core instruction fetches to the icache, a direct uncached AXI read,
// or an access-fault response, and drains killed fetches so buses stay in sync.
module ysyx_22051013_ifetch_router
  import ysyx_22051013_ifetch_router_pkg::*;
#(
  parameter int                        ADDR_W    = 64,
  parameter int                        DATA_W    = 64,
  parameter int                        INST_W    = 32,
  parameter int                        N_UNC     = 2,
  parameter logic [ADDR_W-1:0]         MEM_START = DEF_MEM_START,
  parameter logic [ADDR_W-1:0]         MEM_END   = DEF_MEM_END,
  parameter logic [N_UNC*ADDR_W-1:0]   UNC_START = DEF_UNC_START,
  parameter logic [N_UNC*ADDR_W-1:0]   UNC_END   = DEF_UNC_END
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_valid,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_ready,
  input  logic              core_flush,
  input  logic              fencei,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_fault,
  output logic              icache_ena,
  output logic [ADDR_W-1:0] icache_inst_pc,
  output logic              icache_ready,
  output logic              icache_fencei,
  input  logic              icache_valid,
  input  logic [ADDR_W-1:0] icache_pc,
  input  logic [INST_W-1:0] icache_inst_i,
  input  logic              icache_axi_re,
  input  logic [ADDR_W-1:0] icache_axi_pc,
  output logic [DATA_W-1:0] axi_icache_inst,
  output logic              axi_icache_valid,
  output logic              axi_re,
  output logic [ADDR_W-1:0] axi_inst_pc,
  output logic [2:0]        axi_size,
  input  logic              axi_valid,
  input  logic [DATA_W-1:0] axi_inst_i
);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc_q, w_pc_nxt;
  logic [DATA_W-1:0] r_data_q, w_data_nxt;
  logic              r_drain_cached, w_drain_cached_nxt;
  logic              w_cached, w_uncached, w_unmapped;
  logic              w_cache_side;

  ysyx_22051013_ifetch_region_dec #(
    .ADDR_W   (ADDR_W),
    .N_UNC    (N_UNC),
    .MEM_START(MEM_START),
    .MEM_END  (MEM_END),
    .UNC_START(UNC_START),
    .UNC_END  (UNC_END)
  ) u_region_dec (
    .i_addr    (core_addr),
    .o_cached  (w_cached),
    .o_uncached(w_uncached),
    .o_unmapped(w_unmapped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pc_q         <= '0;
      r_data_q       <= '0;
      r_drain_cached <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc_q         <= w_pc_nxt;
      r_data_q       <= w_data_nxt;
      r_drain_cached <= w_drain_cached_nxt;
    end
  end

  assign icache_fencei = fencei;
  assign w_cache_side  = (r_state == S_CACHED) || ((r_state == S_DRAIN) && r_drain_cached);

  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc_q;
    w_data_nxt         = r_data_q;
    w_drain_cached_nxt = r_drain_cached;
    inst_valid         = 1'b0;
    inst               = '0;
    pc                 = '0;
    inst_fault         = 1'b0;
    icache_ena         = 1'b0;
    icache_inst_pc     = '0;
    icache_ready       = 1'b0;
    axi_icache_inst    = '0;
    axi_icache_valid   = 1'b0;
    axi_re             = 1'b0;
    axi_inst_pc        = '0;
    axi_size           = 3'b000;

    case (r_state)
      S_IDLE: begin
        if (core_valid && !fencei && !core_flush) begin
          w_pc_nxt = core_addr;
          if (w_cached)        w_state_nxt = S_CACHED;
          else if (w_uncached) w_state_nxt = S_UNC_BUSY;
          else if (w_unmapped) w_state_nxt = S_FAULT;
        end
      end
      S_CACHED: begin
        // A flush still acks the icache so a same-cycle beat is consumed, not stranded.
        icache_ready = core_ready | core_flush;
        inst_valid   = icache_valid & ~core_flush;
        inst         = icache_inst_i;
        pc           = icache_pc;
        if (core_flush) begin
          w_drain_cached_nxt = 1'b1;
          w_state_nxt        = icache_valid ? S_IDLE : S_DRAIN;
        end else if (icache_valid && core_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_UNC_BUSY: begin
        axi_re      = 1'b1;
        axi_inst_pc = r_pc_q;
        axi_size    = AXI_SIZE_4B;
        if (axi_valid) begin
          if (core_flush) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_data_nxt  = axi_inst_i;
            w_state_nxt = S_HOLD;
          end
        end else if (core_flush) begin
          w_drain_cached_nxt = 1'b0;
          w_state_nxt        = S_DRAIN;
        end
      end
      S_HOLD: begin
        inst_valid = ~core_flush;
        inst       = r_pc_q[2] ? r_data_q[2*INST_W-1:INST_W] : r_data_q[INST_W-1:0];
        pc         = r_pc_q;
        if (core_flush || core_ready) w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        inst_valid = ~core_flush;
        inst_fault = 1'b1;
        pc         = r_pc_q;
        if (core_flush || core_ready) w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (r_drain_cached) begin
          icache_ready = 1'b1;
          if (icache_valid) w_state_nxt = S_IDLE;
        end else begin
          axi_re      = 1'b1;
          axi_inst_pc = r_pc_q;
          axi_size    = AXI_SIZE_4B;
          if (axi_valid) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // The icache owns the AXI port while a cached fetch (live or draining) is outstanding.
    if (w_cache_side) begin
      icache_ena       = 1'b1;
      icache_inst_pc   = r_pc_q;
      axi_re           = icache_axi_re;
      axi_inst_pc      = icache_axi_pc;
      axi_size         = AXI_SIZE_8B;
      axi_icache_inst  = axi_inst_i;
      axi_icache_valid = axi_valid;
    end
  end

endmodule

// File: doc/ysyx_22051013_ifetch_router.md
YSYX_22051013_IFETCH_ROUTER -- requirements
Module: ysyx_22051013_ifetch_router

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 64, address width; DATA_W, 64, bus beat width; INST_W, 32, instruction width; N_UNC, 2, number of uncached fetch windows; MEM_START/MEM_END, 64'h8000_0000/64'h87FF_FFFF, cached window bounds (inclusive); UNC_START/UNC_END, packed N_UNC*ADDR_W, uncached window bounds (inclusive).
REQ-002 Ports SHALL be (name, direction, width, meaning), one clock, reset asynchronous and active-high:
  clk in 1 clock; rst in 1 asynchronous active-high reset;
  core_valid in 1 fetch request; core_addr in ADDR_W fetch PC; core_ready in 1 core accepts response; core_flush in 1 kill current fetch; fencei in 1 icache invalidate;
  inst_valid out 1 response valid; inst out INST_W instruction; pc out ADDR_W PC of response; inst_fault out 1 access fault;
  icache_ena out 1; icache_inst_pc out ADDR_W; icache_ready out 1; icache_fencei out 1; icache_valid in 1; icache_pc in ADDR_W; icache_inst_i in INST_W;
  icache_axi_re in 1; icache_axi_pc in ADDR_W; axi_icache_inst out DATA_W; axi_icache_valid out 1;
  axi_re out 1 level read request; axi_inst_pc out ADDR_W; axi_size out 3; axi_valid in 1 read data valid; axi_inst_i in DATA_W.

Function
REQ-003 Decode SHALL classify core_addr: cached if within MEM window; else uncached if within any UNC window; else unmapped; cached wins on overlap.
REQ-004 FSM states SHALL be IDLE, CACHED, UNC_BUSY, HOLD, FAULT, DRAIN.
REQ-005 IDLE: on core_valid & ~fencei, SHALL latch core_addr into pc_q and go CACHED / UNC_BUSY / FAULT per decode; fencei=1 blocks acceptance.
REQ-006 CACHED: icache_ena=1, icache_inst_pc=pc_q, icache_ready=core_ready; inst/pc/inst_valid SHALL follow icache_inst_i/icache_pc/icache_valid; icache_valid & core_ready -> IDLE.
REQ-007 axi_re/axi_inst_pc SHALL be icache_axi_re/icache_axi_pc with axi_size=3'b011 in CACHED (and DRAIN from CACHED); axi_icache_inst/axi_icache_valid SHALL mirror axi_inst_i/axi_valid then, else 0.
REQ-008 UNC_BUSY: axi_re=1, axi_inst_pc=pc_q, axi_size=3'b010, held high until axi_valid; on axi_valid latch axi_inst_i into data_q, go HOLD.
REQ-009 HOLD: inst_valid=1, inst=data_q[63:32] if pc_q[2] else data_q[31:0], pc=pc_q; core_ready -> IDLE.
REQ-010 FAULT: inst_valid=1, inst_fault=1, inst=0, pc=pc_q; core_ready -> IDLE; no bus activity.
REQ-011 core_flush in HOLD/FAULT/IDLE SHALL go IDLE next cycle, response dropped; in UNC_BUSY SHALL go DRAIN keeping axi_re=1 until axi_valid; in CACHED SHALL go DRAIN keeping icache_ena=1, icache_ready=1 until icache_valid.
REQ-012 DRAIN: inst_valid=0; data discarded; completion -> IDLE; further core_flush ignored.
REQ-013 core_flush and completion in same cycle SHALL resolve to IDLE with no inst_valid delivered.
REQ-014 icache_fencei SHALL equal fencei combinationally in all states.
REQ-015 inst_valid SHALL be 0 in IDLE and DRAIN; inst_fault SHALL be 1 only in FAULT.
REQ-016 Outside CACHED/DRAIN-cached, icache_ena=0, icache_ready=0, icache_inst_pc=0.
REQ-017 Minimum latency: uncached response one cycle after axi_valid; fault response one cycle after acceptance.

Reset
REQ-018 rst SHALL asynchronously force state IDLE, pc_q=0, data_q=0, drain-source flag=0.
REQ-019 During reset all outputs SHALL be 0 except icache_fencei, which follows fencei.
REQ-020 Reset mid-transaction SHALL abandon it; no drain after reset release.

Structure
REQ-021 State encodings, axi_size codes and default window bounds SHALL live in the shared define include.
REQ-022 Region decode SHALL be sub-module ysyx_22051013_ifetch_region_dec (combinational, N_UNC-parametrised, outputs cached/uncached/unmapped).

Verification
REQ-023 Cached fetch 0x8000_0000, icache_valid after 3 cycles, core_ready=1 -> inst_valid 1 cycle, pc=0x8000_0000, state IDLE.
REQ-024 Uncached 0x1000_0004, axi_valid after 5 cycles with data 0xAAAA_BBBB_CCCC_DDDD -> axi_size=3'b010, inst=0xAAAA_BBBB.
REQ-025 Unmapped 0x0000_0000 -> next cycle inst_valid=1, inst_fault=1, axi_re=0; core_ready=0 for 4 cycles holds response.
REQ-026 core_flush 2 cycles into uncached wait -> axi_re stays 1 until axi_valid, no inst_valid, then IDLE accepts next request.
REQ-027 fencei=1 with core_valid=1 -> no acceptance, icache_fencei=1; rst asserted in UNC_BUSY -> axi_re=0 immediately.
